alu_seq: RTL

//  Parametrised, handshaked successor to the 8-bit combinational ALU.

---
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/result handshake bundle for alu_seq
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cy;
    logic             zero;
    logic             err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, cy, zero, err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, cy, zero, err
    );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked sequential ALU with bit-serial shifts
// ALU_SEQ_MUL_EN adds opcode 1010 as a shift-add multiplier; otherwise 1010 is illegal.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    typedef enum logic [1:0] {K_SHL, K_SHR, K_MUL} kind_t;

    state_t           state, state_nx;
    kind_t            kind, kind_nx;
    logic [WIDTH-1:0] acc, acc_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             cy_r, cy_nx;
    logic             zero_r, zero_nx;
    logic             err_r, err_nx;
    logic [WIDTH:0]   sum;
`ifdef ALU_SEQ_MUL_EN
    // hi:acc holds the running product; acc starts as the multiplier and shifts out LSB-first
    logic [WIDTH-1:0] hi, hi_nx;
    logic [WIDTH-1:0] mcand, mcand_nx;
    logic [WIDTH:0]   hsum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            kind   <= K_SHL;
            acc    <= '0;
            cnt    <= '0;
            cy_r   <= 1'b0;
            zero_r <= 1'b0;
            err_r  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            hi     <= '0;
            mcand  <= '0;
`endif
        end else begin
            state  <= state_nx;
            kind   <= kind_nx;
            acc    <= acc_nx;
            cnt    <= cnt_nx;
            cy_r   <= cy_nx;
            zero_r <= zero_nx;
            err_r  <= err_nx;
`ifdef ALU_SEQ_MUL_EN
            hi     <= hi_nx;
            mcand  <= mcand_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        kind_nx  = kind;
        acc_nx   = acc;
        cnt_nx   = cnt;
        cy_nx    = cy_r;
        zero_nx  = zero_r;
        err_nx   = err_r;
        sum      = '0;
`ifdef ALU_SEQ_MUL_EN
        hi_nx    = hi;
        mcand_nx = mcand;
        hsum     = '0;
`endif
        case (state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_nx = S_DONE;
                    cy_nx    = 1'b0;
                    err_nx   = 1'b0;
                    case (bus.op)
                        4'h0: begin
                            sum    = {1'b0, bus.a} + {1'b0, bus.b};
                            acc_nx = sum[WIDTH-1:0];
                            cy_nx  = sum[WIDTH];
                        end
                        4'h1: begin
                            sum    = {1'b0, bus.a} + (WIDTH+1)'(1);
                            acc_nx = sum[WIDTH-1:0];
                            cy_nx  = sum[WIDTH];
                        end
                        4'h2: begin
                            acc_nx = bus.a - bus.b;
                            cy_nx  = (bus.a < bus.b);
                        end
                        4'h3: begin
                            acc_nx = bus.a - WIDTH'(1);
                            cy_nx  = (bus.a == '0);
                        end
                        4'h4: begin
                            acc_nx = {bus.a[WIDTH-2:0], 1'b0};
                            cy_nx  = bus.a[WIDTH-1];
                        end
                        4'h5: begin
                            acc_nx = {1'b0, bus.a[WIDTH-1:1]};
                            cy_nx  = bus.a[0];
                        end
                        4'h6: acc_nx = ~(bus.a & bus.b);
                        4'h7: acc_nx = (bus.a > bus.b) ? WIDTH'(1) : '0;
                        4'h8, 4'h9: begin
                            acc_nx  = bus.a;
                            kind_nx = bus.op[0] ? K_SHR : K_SHL;
                            cnt_nx  = CW'(bus.b[SHW-1:0]);
                            if (bus.b[SHW-1:0] != '0)
                                state_nx = S_BUSY;
                        end
`ifdef ALU_SEQ_MUL_EN
                        4'hA: begin
                            acc_nx   = bus.b;
                            hi_nx    = '0;
                            mcand_nx = bus.a;
                            kind_nx  = K_MUL;
                            cnt_nx   = CW'(WIDTH);
                            state_nx = S_BUSY;
                        end
`endif
                        default: begin
                            acc_nx = '0;
                            err_nx = 1'b1;
                        end
                    endcase
                    zero_nx = (acc_nx == '0);
                end
            end
            S_BUSY: begin
                cnt_nx = cnt - CW'(1);
                case (kind)
                    K_SHL: begin
                        cy_nx  = acc[WIDTH-1];
                        acc_nx = {acc[WIDTH-2:0], 1'b0};
                    end
                    K_SHR: begin
                        cy_nx  = acc[0];
                        acc_nx = {1'b0, acc[WIDTH-1:1]};
                    end
`ifdef ALU_SEQ_MUL_EN
                    K_MUL: begin
                        hsum            = {1'b0, hi} + (acc[0] ? {1'b0, mcand} : '0);
                        {hi_nx, acc_nx} = {hsum, acc[WIDTH-1:1]};
                        cy_nx           = |hi_nx;
                    end
`endif
                    default: ;
                endcase
                if (cnt == CW'(1)) begin
                    state_nx = S_DONE;
                    zero_nx  = (acc_nx == '0);
                end
            end
            S_DONE: begin
                if (bus.out_ready)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.result    = acc;
    assign bus.cy        = cy_r;
    assign bus.zero      = zero_r;
    assign bus.err       = err_r;
endmodule
